// File: rtl/mem_stage_pkg.sv
// Shared constants for the M-stage memory access block: opcodes, exception
// codes, store-data forward selects, access FSM states and alignment helper.
package mem_stage_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  localparam logic [1:0] FWD_RT     = 2'd0;
  localparam logic [1:0] FWD_WDATA  = 2'd1;
  localparam logic [1:0] FWD_PC8W   = 2'd2;
  localparam logic [1:0] FWD_RT_ALT = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } fsm_state_e;

  function automatic logic misaligned(input logic [5:0] op, input logic [1:0] a);
    logic m;
    case (op)
      OP_LH, OP_LHU, OP_SH: m = a[0];
      OP_LW, OP_SW:         m = (a != 2'b00);
      default:              m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_stage_lat_dm_bank.sv
// Data memory bank: DM_WORDS x 32, byte-enable synchronous write,
// combinational read, whole array cleared by the synchronous active-low reset.
module dm_bank #(
  parameter int DM_WORDS = 1024,
  parameter int ADDR_W   = $clog2(DM_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [DM_WORDS];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DM_WORDS; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage_lat.sv
// Pipeline memory stage with configurable access latency and registered M/W
// outputs. Define MEM_STAGE_ALIGN_EXC_EN to enable address-error exceptions.
module mem_stage_lat
  import mem_stage_pkg::*;
#(
  parameter int DM_WORDS = 1024,
  parameter int MEM_LAT  = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_M,
  input  logic [31:0] PC8_M,
  input  logic [31:0] ALUOUT_M,
  input  logic [31:0] RT_M,
  input  logic [1:0]  Forward_RT_M,
  input  logic [31:0] mux_Wdata_out,
  input  logic [31:0] PC8_W_out,
  output logic        stall_M,
  output logic [31:0] IR_W,
  output logic [31:0] PC8_W,
  output logic [31:0] ALUOUT_W,
  output logic [31:0] DMOUT_W
`ifdef MEM_STAGE_ALIGN_EXC_EN
  ,
  output logic        exc_W,
  output logic [4:0]  exc_code_W
`endif
);

  localparam int ADDR_W = $clog2(DM_WORDS);
  localparam int AW2    = ADDR_W + 2;

  logic [5:0]     op;
  logic           is_load, is_store, is_mem;
  logic [31:0]    fwd_data, wdata_now, acc_wdata, rdata, shifted, load_data;
  logic [3:0]     be_now, acc_be;
  logic [AW2-1:0] acc_addr;
  logic           acc_fire, acc_mis;

  assign op       = IR_M[31:26];
  assign is_load  = op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  assign is_store = op inside {OP_SB, OP_SH, OP_SW};
  assign is_mem   = is_load | is_store;

  always_comb begin
    case (Forward_RT_M)
      FWD_WDATA: fwd_data = mux_Wdata_out;
      FWD_PC8W:  fwd_data = PC8_W_out;
      default:   fwd_data = RT_M;
    endcase
  end

  // Lane enables and replicated data for the access starting this cycle.
  always_comb begin
    be_now    = 4'b0000;
    wdata_now = fwd_data;
    case (op)
      OP_SB: begin
        be_now    = 4'b0001 << ALUOUT_M[1:0];
        wdata_now = {4{fwd_data[7:0]}};
      end
      OP_SH: begin
        be_now    = 4'b0011 << {ALUOUT_M[1], 1'b0};
        wdata_now = {2{fwd_data[15:0]}};
      end
      OP_SW:   be_now = 4'b1111;
      default: be_now = 4'b0000;
    endcase
`ifdef MEM_STAGE_ALIGN_EXC_EN
    if (misaligned(op, ALUOUT_M[1:0])) be_now = 4'b0000;
`endif
  end

  generate
    if (MEM_LAT == 0) begin : g_lat0
      assign acc_addr  = ALUOUT_M[AW2-1:0];
      assign acc_wdata = wdata_now;
      assign acc_be    = be_now;
      assign acc_fire  = is_mem;
      assign stall_M   = 1'b0;
    end else begin : g_fsm
      localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);
      fsm_state_e     state_q;
      logic [3:0]     cnt_q;
      logic [AW2-1:0] addr_q;
      logic [31:0]    wdata_q;
      logic [3:0]     be_q;

      // Forward sources move on while M is held, so capture them on entry.
      always_ff @(posedge clk) begin
        if (!reset) begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          addr_q  <= '0;
          wdata_q <= '0;
          be_q    <= '0;
        end else begin
          case (state_q)
            ST_IDLE: if (is_mem) begin
              state_q <= ST_BUSY;
              cnt_q   <= CNT_INIT;
              addr_q  <= ALUOUT_M[AW2-1:0];
              wdata_q <= wdata_now;
              be_q    <= be_now;
            end
            ST_BUSY: begin
              if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
              else               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
          endcase
        end
      end

      assign stall_M   = (state_q == ST_IDLE) ? is_mem : (cnt_q != 4'd0);
      assign acc_fire  = (state_q == ST_BUSY) && (cnt_q == 4'd0);
      assign acc_addr  = addr_q;
      assign acc_wdata = wdata_q;
      assign acc_be    = be_q;
    end
  endgenerate

  dm_bank #(.DM_WORDS(DM_WORDS), .ADDR_W(ADDR_W)) u_dm (
    .clk     (clk),
    .reset   (reset),
    .we_i    (acc_fire & is_store),
    .be_i    (acc_be),
    .addr_i  (acc_addr[AW2-1:2]),
    .wdata_i (acc_wdata),
    .rdata_o (rdata)
  );

  assign acc_mis = misaligned(op, acc_addr[1:0]);
  assign shifted = rdata >> {acc_addr[1:0], 3'b000};

  always_comb begin
    case (op)
      OP_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
      OP_LBU:  load_data = {24'h0, shifted[7:0]};
      OP_LH:   load_data = acc_addr[1] ? {{16{rdata[31]}}, rdata[31:16]}
                                       : {{16{rdata[15]}}, rdata[15:0]};
      OP_LHU:  load_data = acc_addr[1] ? {16'h0, rdata[31:16]} : {16'h0, rdata[15:0]};
      OP_LW:   load_data = rdata;
      default: load_data = 32'h0;
    endcase
`ifdef MEM_STAGE_ALIGN_EXC_EN
    if (acc_mis) load_data = 32'h0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset || stall_M) begin
      IR_W     <= '0;
      PC8_W    <= '0;
      ALUOUT_W <= '0;
      DMOUT_W  <= '0;
    end else begin
      IR_W     <= IR_M;
      PC8_W    <= PC8_M;
      ALUOUT_W <= ALUOUT_M;
      DMOUT_W  <= is_load ? load_data : 32'h0;
    end
  end

`ifdef MEM_STAGE_ALIGN_EXC_EN
  always_ff @(posedge clk) begin
    if (!reset || stall_M) begin
      exc_W      <= 1'b0;
      exc_code_W <= '0;
    end else begin
      exc_W      <= is_mem & acc_mis;
      exc_code_W <= (is_mem & acc_mis) ? (is_load ? EXC_ADEL : EXC_ADES) : 5'd0;
    end
  end
`else
  logic unused_mis;
  assign unused_mis = acc_mis;
`endif

endmodule

// File: tb/tb_mem_stage_lat.sv
// Directed bench for mem_stage_lat: three instances (latency 0, 2, 3) share
// one input stream; each phase checks only the instance it targets.
module tb_mem_stage_lat;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] ir_m = '0, pc8_m = 32'h3000, alu_m = '0, rt_m = '0;
  logic [31:0] wdata = '0, pc8w = '0;
  logic [1:0]  fwd = '0;

  logic        st0, st2, st3;
  logic [31:0] irw0, pcw0, aluw0, dmw0;
  logic [31:0] irw2, pcw2, aluw2, dmw2;
  logic [31:0] irw3, pcw3, aluw3, dmw3;
`ifdef MEM_STAGE_ALIGN_EXC_EN
  logic        exc0, exc2, exc3;
  logic [4:0]  code0, code2, code3;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_stage_lat #(.DM_WORDS(1024), .MEM_LAT(0)) u_lat0 (
`ifdef MEM_STAGE_ALIGN_EXC_EN
    .exc_W(exc0), .exc_code_W(code0),
`endif
    .clk(clk), .reset(reset), .IR_M(ir_m), .PC8_M(pc8_m), .ALUOUT_M(alu_m),
    .RT_M(rt_m), .Forward_RT_M(fwd), .mux_Wdata_out(wdata), .PC8_W_out(pc8w),
    .stall_M(st0), .IR_W(irw0), .PC8_W(pcw0), .ALUOUT_W(aluw0), .DMOUT_W(dmw0)
  );

  mem_stage_lat #(.DM_WORDS(16), .MEM_LAT(2)) u_lat2 (
`ifdef MEM_STAGE_ALIGN_EXC_EN
    .exc_W(exc2), .exc_code_W(code2),
`endif
    .clk(clk), .reset(reset), .IR_M(ir_m), .PC8_M(pc8_m), .ALUOUT_M(alu_m),
    .RT_M(rt_m), .Forward_RT_M(fwd), .mux_Wdata_out(wdata), .PC8_W_out(pc8w),
    .stall_M(st2), .IR_W(irw2), .PC8_W(pcw2), .ALUOUT_W(aluw2), .DMOUT_W(dmw2)
  );

  mem_stage_lat #(.DM_WORDS(1024), .MEM_LAT(3)) u_lat3 (
`ifdef MEM_STAGE_ALIGN_EXC_EN
    .exc_W(exc3), .exc_code_W(code3),
`endif
    .clk(clk), .reset(reset), .IR_M(ir_m), .PC8_M(pc8_m), .ALUOUT_M(alu_m),
    .RT_M(rt_m), .Forward_RT_M(fwd), .mux_Wdata_out(wdata), .PC8_W_out(pc8w),
    .stall_M(st3), .IR_W(irw3), .PC8_W(pcw3), .ALUOUT_W(aluw3), .DMOUT_W(dmw3)
  );

  function automatic logic [31:0] mk_ir(input logic [5:0] op);
    return {op, 26'h0108000};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] alu,
                       input logic [31:0] rt, input logic [1:0] fs);
    ir_m  = mk_ir(op);
    alu_m = alu;
    rt_m  = rt;
    fwd   = fs;
    pc8_m = pc8_m + 32'd4;
  endtask

  // Single-cycle instance: no stall, result visible right after the edge.
  task automatic step0(input string tag, input logic [5:0] op, input logic [31:0] alu,
                       input logic [31:0] rt, input logic [1:0] fs, input logic [31:0] exp_dm);
    issue(op, alu, rt, fs);
    #1;
    chk({tag, "_stall"}, {31'h0, st0}, 32'h0);
    tick();
    chk({tag, "_ir"}, irw0, ir_m);
    chk({tag, "_pc8"}, pcw0, pc8_m);
    chk({tag, "_dm"}, dmw0, exp_dm);
  endtask

  // Multi-cycle instance: hold M while stalled, swap the W forward source
  // after the first cycle, count stall cycles and check each bubble.
  task automatic lat_access(input int which, input string tag, input logic [5:0] op,
                            input logic [31:0] alu, input logic [31:0] rt,
                            input logic [1:0] fs, input logic [31:0] late_wdata,
                            input int exp_stalls, input logic [31:0] exp_dm);
    int   stalls;
    logic s;
    stalls = 0;
    issue(op, alu, rt, fs);
    #1;
    for (int c = 0; c < 20; c++) begin
      s = (which == 3) ? st3 : st2;
      if (!s) break;
      stalls++;
      tick();
      chk({tag, "_bubble_ir"}, (which == 3) ? irw3 : irw2, 32'h0);
      chk({tag, "_bubble_dm"}, (which == 3) ? dmw3 : dmw2, 32'h0);
      wdata = late_wdata;
      pc8w  = pc8w + 32'h100;
      #1;
    end
    chk({tag, "_stalls"}, 32'(stalls), 32'(exp_stalls));
    tick();
    chk({tag, "_ir"}, (which == 3) ? irw3 : irw2, ir_m);
    chk({tag, "_pc8"}, (which == 3) ? pcw3 : pcw2, pc8_m);
    chk({tag, "_dm"}, (which == 3) ? dmw3 : dmw2, exp_dm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    ir_m = mk_ir(OP_SW);
    alu_m = 32'h10;
    rt_m = 32'hFFFF_FFFF;
    tick();
    reset = 1'b0;
    tick();
    chk("rst_ir_w0", irw0, 32'h0);
    chk("rst_pc8_w0", pcw0, 32'h0);
    chk("rst_alu_w0", aluw0, 32'h0);
    chk("rst_dm_w0", dmw0, 32'h0);
    chk("rst_ir_w2", irw2, 32'h0);
    chk("rst_ir_w3", irw3, 32'h0);
    chk("rst_alu_w3", aluw3, 32'h0);
    reset = 1'b1;

    // Latency 0: store, then immediate load of the same word.
    step0("sw_dead",  OP_SW, 32'h10, 32'hDEAD_BEEF, FWD_RT, 32'h0);
    step0("lw_dead",  OP_LW, 32'h10, 32'h0,         FWD_RT, 32'hDEAD_BEEF);
    chk("lw_dead_alu", aluw0, 32'h10);
    step0("sw_base",  OP_SW, 32'h10, 32'h1122_3344, FWD_RT, 32'h0);
    step0("sb_aa",    OP_SB, 32'h13, 32'h0000_00AA, FWD_RT, 32'h0);
    step0("lb_aa",    OP_LB, 32'h13, 32'h0,         FWD_RT, 32'hFFFF_FFAA);
    step0("lbu_aa",   OP_LBU, 32'h13, 32'h0,        FWD_RT, 32'h0000_00AA);
    step0("lw_aa",    OP_LW, 32'h10, 32'h0,         FWD_RT, 32'hAA22_3344);
    step0("lh_hi",    OP_LH, 32'h12, 32'h0,         FWD_RT, 32'hFFFF_AA22);
    step0("lhu_hi",   OP_LHU, 32'h12, 32'h0,        FWD_RT, 32'h0000_AA22);
    step0("sh_lo",    OP_SH, 32'h10, 32'h0000_8001, FWD_RT, 32'h0);
    step0("lh_lo",    OP_LH, 32'h10, 32'h0,         FWD_RT, 32'hFFFF_8001);
    step0("lb_b1",    OP_LB, 32'h11, 32'h0,         FWD_RT, 32'hFFFF_FF80);
    step0("lbu_b0",   OP_LBU, 32'h10, 32'h0,        FWD_RT, 32'h0000_0001);

    // Store-data forwarding selects.
    pc8w = 32'h0000_3008;
    step0("sw_fpc8",  OP_SW, 32'h40, 32'h1, FWD_PC8W, 32'h0);
    step0("lw_fpc8",  OP_LW, 32'h40, 32'h0, FWD_RT,   32'h0000_3008);
    step0("sw_frt3",  OP_SW, 32'h44, 32'h5A5A_A5A5, FWD_RT_ALT, 32'h0);
    step0("lw_frt3",  OP_LW, 32'h44, 32'h0, FWD_RT,   32'h5A5A_A5A5);
    wdata = 32'h7766_5544;
    step0("sw_fwd1",  OP_SW, 32'h48, 32'h1, FWD_WDATA, 32'h0);
    step0("lw_fwd1",  OP_LW, 32'h48, 32'h0, FWD_RT,    32'h7766_5544);

    // Address wraps modulo 1024 words; non-memory op passes through.
    step0("lw_wrap",  OP_LW, 32'h1010, 32'h0, FWD_RT, 32'hAA22_8001);
    step0("nop",      6'h00, 32'h1234, 32'h0, FWD_RT, 32'h0);
    chk("nop_alu", aluw0, 32'h1234);

    // Misaligned accesses.
    step0("sw_cafe",  OP_SW, 32'h20, 32'hCAFE_F00D, FWD_RT, 32'h0);
`ifdef MEM_STAGE_ALIGN_EXC_EN
    chk("sw_cafe_exc", {31'h0, exc0}, 32'h0);
    step0("lw_mis",   OP_LW, 32'h22, 32'h0, FWD_RT, 32'h0);
    chk("lw_mis_exc", {31'h0, exc0}, 32'h1);
    chk("lw_mis_code", {27'h0, code0}, 32'd4);
    step0("sw_mis",   OP_SW, 32'h21, 32'h1111_1111, FWD_RT, 32'h0);
    chk("sw_mis_exc", {31'h0, exc0}, 32'h1);
    chk("sw_mis_code", {27'h0, code0}, 32'd5);
    step0("lw_after", OP_LW, 32'h20, 32'h0, FWD_RT, 32'hCAFE_F00D);
`else
    step0("lw_mis",   OP_LW, 32'h22, 32'h0, FWD_RT, 32'hCAFE_F00D);
    step0("sw_mis",   OP_SW, 32'h21, 32'h1111_1111, FWD_RT, 32'h0);
    step0("lw_after", OP_LW, 32'h20, 32'h0, FWD_RT, 32'h1111_1111);
`endif

    // Latency 3: three stall cycles and bubbles per access.
    do_reset();
    lat_access(3, "l3_sw", OP_SW, 32'h30, 32'h0BAD_F00D, FWD_RT, 32'h0, 3, 32'h0);
    lat_access(3, "l3_lw", OP_LW, 32'h30, 32'h0, FWD_RT, 32'h0, 3, 32'h0BAD_F00D);
    lat_access(3, "l3_lbu", OP_LBU, 32'h32, 32'h0, FWD_RT, 32'h0, 3, 32'h0000_00AD);

    // Latency 2: forward source is captured only in the first cycle.
    do_reset();
    wdata = 32'h1234_5678;
    lat_access(2, "l2_sw", OP_SW, 32'h50, 32'h0, FWD_WDATA, 32'h9999_0000, 2, 32'h0);
    lat_access(2, "l2_lw", OP_LW, 32'h50, 32'h0, FWD_RT, 32'h0, 2, 32'h1234_5678);
    lat_access(2, "l2_wrap", OP_LW, 32'h10, 32'h0, FWD_RT, 32'h0, 2, 32'h1234_5678);

    // Reset during BUSY aborts the pending store.
    do_reset();
    issue(OP_SW, 32'h20, 32'h55, FWD_RT);
    #1;
    chk("abort_stall0", {31'h0, st3}, 32'h1);
    tick();
    chk("abort_stall1", {31'h0, st3}, 32'h1);
    reset = 1'b0;
    ir_m = mk_ir(6'h00);
    tick();
    reset = 1'b1;
    #1;
    chk("abort_idle", {31'h0, st3}, 32'h0);
    chk("abort_irw", irw3, 32'h0);
    tick();
    chk("abort_nop_ir", irw3, mk_ir(6'h00));
    lat_access(3, "abort_lw", OP_LW, 32'h20, 32'h0, FWD_RT, 32'h0, 3, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_lat.md
# mem_stage_lat

Parametrised successor to the pipeline memory stage. It sits between the E/M and M/W pipeline registers of the 5-stage MIPS core. It resolves store-data forwarding, performs word/half/byte loads and stores against a sized data memory, and models a configurable memory latency. It raises `stall_M` to the hazard unit while an access is outstanding, and registers all W-stage outputs.

## Interface
Parameters:
- `DM_WORDS`, 1024: data memory depth in 32-bit words; power of two, 16..65536.
- `MEM_LAT`, 0: extra cycles per load/store, 0..15. 0 means single-cycle access.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low reset.
- `IR_M`  in  32  instruction in M.
- `PC8_M`  in  32  PC+8 of instruction in M.
- `ALUOUT_M`  in  32  effective address or ALU result.
- `RT_M`  in  32  rt value from the E/M register.
- `Forward_RT_M`  in  2  store-data select: 0 RT_M, 1 mux_Wdata_out, 2 PC8_W_out, 3 RT_M.
- `mux_Wdata_out`  in  32  W-stage writeback data.
- `PC8_W_out`  in  32  W-stage PC+8.
- `stall_M`  out  1  instruction in M must be held; combinational.
- `IR_W`, `PC8_W`, `ALUOUT_W`, `DMOUT_W`  out  32 each  registered M/W outputs.
- `exc_W`  out  1  address-error flag. Present only with the configuration macro.
- `exc_code_W`  out  5  4 = AdEL, 5 = AdES. Present only with the configuration macro.

## Operation
- Decode from `IR_M[31:26]`:
  - loads: lb 0x20, lh 0x21, lw 0x23, lbu 0x24, lhu 0x25.
  - stores: sb 0x28, sh 0x29, sw 0x2B.
  - `is_mem` = load or store.
- Memory address:
  - word index = `ALUOUT_M[ADDR_W+1:2]`, where `ADDR_W = $clog2(DM_WORDS)`.
  - Upper address bits are ignored, so addresses wrap modulo `DM_WORDS`.
- Store byte enables (little-endian):
  - sb: `1 << ALUOUT_M[1:0]`.
  - sh: `4'b0011 << {ALUOUT_M[1],1'b0}`.
  - sw: `4'b1111`.
- Store data is the forwarded value, replicated into the enabled lanes.
- Load extraction: select the addressed byte or half of the word read.
  - lb/lh sign-extend; lbu/lhu zero-extend.
- FSM states are IDLE and BUSY. All FSM logic is tied off when `MEM_LAT` = 0.
  - IDLE with `is_mem`:
    - `stall_M` = 1.
    - Latch store data, address and byte enables.
    - Load `cnt` with `MEM_LAT-1`; go to BUSY.
  - BUSY with `cnt` != 0: `stall_M` = 1; `cnt` decrements.
  - BUSY with `cnt` == 0:
    - `stall_M` = 0.
    - Commit the write, or capture load data, from the latched address.
    - Go to IDLE.
  - Store data is latched on the first cycle because the W-stage forward source advances while M is stalled.
- Each load/store occupies M for `MEM_LAT+1` cycles. Each store writes exactly once.
- Non-memory instructions never stall.
- While `stall_M` = 1, the M/W register loads a bubble: all W outputs are 0.
- When not stalled, `IR_W`/`PC8_W`/`ALUOUT_W` take the M values. `DMOUT_W` takes load data, or 0 for non-loads.

## Timing
- Reset, when `reset` = 0 at a rising edge:
  - all W outputs become 0;
  - FSM goes to IDLE, `cnt` to 0;
  - memory array is cleared to 0.
- Reset during BUSY aborts the access; the pending store is never written.
- With `MEM_LAT` = 0:
  - the write commits at the edge ending the M cycle;
  - load data appears on `DMOUT_W` one cycle after the instruction is in M.
- With `MEM_LAT` = N, load data appears on `DMOUT_W` N+1 cycles after the instruction enters M.
- A store followed immediately by a load to the same word: the load returns the new data, because the write edge precedes the load's read.
- `Forward_RT_M` is sampled only in the access's first M cycle.

## Configuration
- `MEM_STAGE_ALIGN_EXC_EN` defined:
  - Misalignment checks: lh/lhu/sh with `addr[0]` = 1; lw/sw with `addr[1:0]` != 0.
  - A misaligned store writes nothing.
  - A misaligned load returns `DMOUT_W` = 0.
  - `exc_W` = 1 with code 4 (load) or 5 (store), registered with the instruction.
  - Misaligned accesses still take full latency.
- Undefined:
  - The offending low address bits are forced to 0 (aligned access).
  - No exception ports exist.

## Structure
- Package `mem_stage_pkg` holds:
  - opcode constants;
  - exception codes (AdEL = 4, AdES = 5);
  - forward-select constants;
  - FSM state enum.
- Sub-module `dm_bank`: `DM_WORDS`×32 array with 4-bit byte-enable synchronous write, combinational read, and synchronous clear on reset.

## Test plan
- Reset, then sw 0xDEADBEEF to addr 0x10, then lw from 0x10 → `DMOUT_W` = 0xDEADBEEF; after reset all W outputs read 0.
- sb 0x000000AA to 0x13 over word 0x11223344, then lb/lbu from 0x13 → 0xFFFFFFAA / 0x000000AA; lw → 0xAA223344.
- `MEM_LAT` = 3, sw then lw to same address → `stall_M` high 3 cycles each; three bubbles on `IR_W`; single write observed; load returns the stored value.
- `MEM_LAT` = 2, `Forward_RT_M` = 1 with `mux_Wdata_out` = 0x12345678 in the first cycle, changing afterwards → memory holds 0x12345678.
- Reset asserted during BUSY of sw 0x55 to 0x20 → location 0x20 stays 0; FSM returns to IDLE; `stall_M` = 0.
- With `MEM_STAGE_ALIGN_EXC_EN`, lw from 0x22 → `exc_W` = 1, `exc_code_W` = 4, `DMOUT_W` = 0. Without the macro, the same lw returns the word at 0x20.
